ibex_tsmap_arb: RTL and testbench
=================================

Name: ibex_tsmap_arb

Overview:
- Two-requester arbiter for the single-port temporal-safety (TS) map SRAM.
- The core's TS map port is fixed-latency and cannot be stalled, so the core always wins.
- The external agent (revocation sweeper / host loader) uses a req/gnt/rvalid handshake and is granted only in core-idle cycles.
- The block tracks external starvation and accumulates stall statistics for software visibility.

Parameters:
- TSMapSize, 1024, number of 32-bit words in the TS map SRAM; legal word index 0..TSMapSize-1.
- StarveLimit, 15, consecutive ungranted ext request cycles before ext_starve_o asserts.
- StallCntW, 16, width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- core_cs_i  in  1  core TS map read strobe
- core_addr_i  in  16  core word index
- core_rdata_o  out  32  core read data, valid the cycle after core_cs_i
- core_rdata_intg_o  out  7  core read data integrity bits
- ext_req_i  in  1  ext request
- ext_we_i  in  1  ext write (1) / read (0)
- ext_addr_i  in  16  ext word index
- ext_wdata_i  in  32  ext write data
- ext_wdata_intg_i  in  7  ext write integrity bits, passed through unmodified
- ext_gnt_o  out  1  ext request accepted this cycle
- ext_rvalid_o  out  1  ext response valid
- ext_rdata_o  out  32  ext read data
- ext_rdata_intg_o  out  7  ext read integrity bits
- ext_err_o  out  1  ext response error (out-of-range index)
- mem_cs_o  out  1  SRAM chip select
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  16  SRAM word index
- mem_wdata_o  out  32  SRAM write data
- mem_wdata_intg_o  out  7  SRAM write integrity bits
- mem_rdata_i  in  32  SRAM read data, 1-cycle latency
- mem_rdata_intg_i  in  7  SRAM read integrity bits
- ext_starve_o  out  1  ext starved for at least StarveLimit cycles
- ext_stall_cnt_o  out  StallCntW  total ext stall cycles, saturating

Behaviour:
- **Reset (rst_i=1, async):** all registered state cleared. ext_rvalid_o=0, ext_err_o=0, ext_starve_o=0, ext_stall_cnt_o=0. A response pending at reset is dropped and never reported.
- **Arbitration (combinational, same cycle):**
  - core_cs_i=1: mem_cs_o=1, mem_we_o=0, mem_addr_o=core_addr_i, ext_gnt_o=0.
  - core_cs_i=0 and ext_req_i=1: ext_gnt_o=1. If ext_addr_i < TSMapSize, drive mem_cs_o=1, mem_we_o=ext_we_i, mem_addr_o=ext_addr_i and wdata/intg from ext.
  - Ext out-of-range (ext_addr_i >= TSMapSize): still granted, mem_cs_o=0, error response follows.
  - Otherwise: mem_cs_o=0, mem_we_o=0, mem_addr_o/mem_wdata_o=0.
- **Core address:** no range check; the core guarantees legal indices.
- **Response pipeline:** one register stage.
  - Registered fields: ext_pend_q (= ext_gnt_o) and ext_err_q (= gnt & out-of-range).
  - Cycle after grant: ext_rvalid_o=1. Writes are acknowledged the same way.
  - ext_err_o=ext_err_q; ext_rdata_o/intg = mem_rdata_i/intg, or 0 when ext_err_q or the granted access was a write.
  - core_rdata_o/intg = mem_rdata_i/intg unconditionally; the core samples them only in its fixed slot.
- **Throughput:** back-to-back ext grants allowed, one per idle cycle. No outstanding limit beyond the pipeline depth of 1.
- **Ext handshake rule:** while ext_req_i=1 and ext_gnt_o=0, the requester holds we/addr/wdata/intg stable. Checked by assertion. Dropping ext_req_i before grant is legal (abort).
- **Starvation counter (starve_q):**
  - Increments each cycle ext_req_i=1 and ext_gnt_o=0, saturating at StarveLimit.
  - Clears to 0 on grant or when ext_req_i=0.
  - ext_starve_o = (starve_q == StarveLimit), registered.
- **Stall counter:** ext_stall_cnt_o increments on each ext_req_i & ~ext_gnt_o cycle, saturating at 2^StallCntW-1. It never wraps and clears only on reset.
- **Simultaneous events:**
  - Core read and ext write to the same index in the same cycle: core wins, ext waits.
  - Ext write in cycle N, core read of the same index in N+1: the core sees the new data (SRAM ordering).

Test Plan:
- **Core priority:** core_cs_i=1 at addr 0x010 and ext_req_i=1 read at 0x020 in the same cycle. Expect mem_addr_o=0x010, ext_gnt_o=0. Next cycle core_cs_i=0: ext_gnt_o=1, mem_addr_o=0x020; one cycle later ext_rvalid_o=1 with ext_rdata_o = SRAM[0x020].
- **Back-to-back ext write then read:** core idle; write 0xDEADBEEF to 0x005, then read 0x005 on the next cycle. Expect two consecutive grants; the second rvalid carries ext_rdata_o=0xDEADBEEF, and the write rvalid carries ext_rdata_o=0.
- **Out-of-range:** ext read at addr 0x0400 with TSMapSize=1024. Expect ext_gnt_o=1, mem_cs_o=0; next cycle ext_rvalid_o=1, ext_err_o=1, ext_rdata_o=0.
- **Starvation:** hold core_cs_i=1 for 20 cycles with ext_req_i=1. Expect ext_starve_o=1 from the cycle after the 15th stall; ext_stall_cnt_o=20. Release core: grant, then ext_starve_o=0 the next cycle.
- **Stall counter saturation:** with StallCntW=4, stall for 20 cycles. Expect ext_stall_cnt_o stays at 15 and does not wrap to 4.
- **Reset mid-operation:** assert rst_i in the cycle between ext grant and rvalid. Expect ext_rvalid_o=0 immediately (async), no response after release, and both counters at 0.

Source files
------------

// File: rtl/ibex_tsmap_arb.sv
// Core/external arbiter for the single-port temporal-safety map SRAM.
// The core always wins; the external agent is served in core-idle cycles.
module ibex_tsmap_arb #(
  parameter int unsigned TSMapSize   = 1024,
  parameter int unsigned StarveLimit = 15,
  parameter int unsigned StallCntW   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 core_cs_i,
  input  logic [15:0]          core_addr_i,
  output logic [31:0]          core_rdata_o,
  output logic [6:0]           core_rdata_intg_o,

  input  logic                 ext_req_i,
  input  logic                 ext_we_i,
  input  logic [15:0]          ext_addr_i,
  input  logic [31:0]          ext_wdata_i,
  input  logic [6:0]           ext_wdata_intg_i,
  output logic                 ext_gnt_o,
  output logic                 ext_rvalid_o,
  output logic [31:0]          ext_rdata_o,
  output logic [6:0]           ext_rdata_intg_o,
  output logic                 ext_err_o,

  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [15:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [6:0]           mem_wdata_intg_o,
  input  logic [31:0]          mem_rdata_i,
  input  logic [6:0]           mem_rdata_intg_i,

  output logic                 ext_starve_o,
  output logic [StallCntW-1:0] ext_stall_cnt_o
);

  localparam int unsigned StarveW = $clog2(StarveLimit + 1);
  localparam logic [StarveW-1:0]   StarveMax = StarveW'(StarveLimit);
  localparam logic [StallCntW-1:0] StallMax  = {StallCntW{1'b1}};

  logic                 ext_in_range;
  logic                 ext_stall;
  logic                 ext_pend_d, ext_pend_q;
  logic                 ext_err_d, ext_err_q;
  logic                 ext_we_d, ext_we_q;
  logic [StarveW-1:0]   starve_d, starve_q;
  logic [StallCntW-1:0] stall_cnt_d, stall_cnt_q;

  assign ext_in_range = 32'(ext_addr_i) < TSMapSize;

  // Same-cycle arbitration onto the SRAM port.
  always_comb begin
    mem_cs_o         = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = 16'h0;
    mem_wdata_o      = 32'h0;
    mem_wdata_intg_o = 7'h0;
    ext_gnt_o        = 1'b0;
    if (core_cs_i) begin
      mem_cs_o   = 1'b1;
      mem_addr_o = core_addr_i;
    end else if (ext_req_i) begin
      ext_gnt_o = 1'b1;
      if (ext_in_range) begin
        mem_cs_o         = 1'b1;
        mem_we_o         = ext_we_i;
        mem_addr_o       = ext_addr_i;
        mem_wdata_o      = ext_wdata_i;
        mem_wdata_intg_o = ext_wdata_intg_i;
      end
    end
  end

  assign ext_stall = ext_req_i & ~ext_gnt_o;

  always_comb begin
    ext_pend_d  = ext_gnt_o;
    ext_err_d   = ext_gnt_o & ~ext_in_range;
    ext_we_d    = ext_gnt_o & ext_we_i;
    starve_d    = '0;
    stall_cnt_d = stall_cnt_q;
    if (ext_stall) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StarveW'(1);
      if (stall_cnt_q != StallMax) begin
        stall_cnt_d = stall_cnt_q + StallCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ext_pend_q  <= 1'b0;
      ext_err_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      starve_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      ext_err_q   <= ext_err_d;
      ext_we_q    <= ext_we_d;
      starve_q    <= starve_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Error and write responses carry no data.
  assign ext_rvalid_o      = ext_pend_q;
  assign ext_err_o         = ext_err_q;
  assign ext_rdata_o       = (ext_err_q | ext_we_q) ? 32'h0 : mem_rdata_i;
  assign ext_rdata_intg_o  = (ext_err_q | ext_we_q) ? 7'h0 : mem_rdata_intg_i;
  assign core_rdata_o      = mem_rdata_i;
  assign core_rdata_intg_o = mem_rdata_intg_i;
  assign ext_starve_o      = (starve_q == StarveMax);
  assign ext_stall_cnt_o   = stall_cnt_q;

  // A waiting requester must keep its request payload stable until granted.
  ext_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (ext_req_i && !ext_gnt_o) |=> (!ext_req_i ||
      ($stable(ext_we_i) && $stable(ext_addr_i) &&
       $stable(ext_wdata_i) && $stable(ext_wdata_intg_i))));

endmodule

// File: tb/tb_ibex_tsmap_arb.sv
// Directed bench for ibex_tsmap_arb with a behavioural 1-cycle SRAM.
// A second instance with a 4-bit stall counter checks saturation.
module tb_ibex_tsmap_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_cs_i;
  logic [15:0] core_addr_i;
  logic        ext_req_i;
  logic        ext_we_i;
  logic [15:0] ext_addr_i;
  logic [31:0] ext_wdata_i;
  logic [6:0]  ext_wdata_intg_i;
  logic [31:0] mem_rdata_i;
  logic [6:0]  mem_rdata_intg_i;

  logic [31:0] core_rdata_o;
  logic [6:0]  core_rdata_intg_o;
  logic        ext_gnt_o, ext_rvalid_o, ext_err_o;
  logic [31:0] ext_rdata_o;
  logic [6:0]  ext_rdata_intg_o;
  logic        mem_cs_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [6:0]  mem_wdata_intg_o;
  logic        ext_starve_o;
  logic [15:0] ext_stall_cnt_o;

  logic [31:0] d2_core_rdata;
  logic [6:0]  d2_core_rdata_intg;
  logic        d2_gnt, d2_rvalid, d2_err;
  logic [31:0] d2_rdata;
  logic [6:0]  d2_rdata_intg;
  logic        d2_mem_cs, d2_mem_we;
  logic [15:0] d2_mem_addr;
  logic [31:0] d2_mem_wdata;
  logic [6:0]  d2_mem_wdata_intg;
  logic        d2_starve;
  logic [3:0]  d2_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ibex_tsmap_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_cs_i(core_cs_i), .core_addr_i(core_addr_i),
    .core_rdata_o(core_rdata_o), .core_rdata_intg_o(core_rdata_intg_o),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i), .ext_wdata_intg_i(ext_wdata_intg_i),
    .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o),
    .ext_rdata_o(ext_rdata_o), .ext_rdata_intg_o(ext_rdata_intg_o),
    .ext_err_o(ext_err_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wdata_intg_o(mem_wdata_intg_o),
    .mem_rdata_i(mem_rdata_i), .mem_rdata_intg_i(mem_rdata_intg_i),
    .ext_starve_o(ext_starve_o), .ext_stall_cnt_o(ext_stall_cnt_o)
  );

  ibex_tsmap_arb #(.StallCntW(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_cs_i(core_cs_i), .core_addr_i(core_addr_i),
    .core_rdata_o(d2_core_rdata), .core_rdata_intg_o(d2_core_rdata_intg),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i), .ext_wdata_intg_i(ext_wdata_intg_i),
    .ext_gnt_o(d2_gnt), .ext_rvalid_o(d2_rvalid),
    .ext_rdata_o(d2_rdata), .ext_rdata_intg_o(d2_rdata_intg),
    .ext_err_o(d2_err),
    .mem_cs_o(d2_mem_cs), .mem_we_o(d2_mem_we), .mem_addr_o(d2_mem_addr),
    .mem_wdata_o(d2_mem_wdata), .mem_wdata_intg_o(d2_mem_wdata_intg),
    .mem_rdata_i(mem_rdata_i), .mem_rdata_intg_i(mem_rdata_intg_i),
    .ext_starve_o(d2_starve), .ext_stall_cnt_o(d2_stall_cnt)
  );

  // Behavioural SRAM driven by the main instance; preloaded on the first edge.
  logic [31:0] mem  [1024];
  logic [6:0]  memi [1024];
  logic        preload = 1'b1;

  always @(posedge clk_i) begin
    if (preload) begin
      mem[10'h010] <= 32'hCAFE0010; memi[10'h010] <= 7'h10;
      mem[10'h020] <= 32'h12345678; memi[10'h020] <= 7'h2A;
      mem[10'h3FF] <= 32'h000003FF; memi[10'h3FF] <= 7'h7F;
      preload      <= 1'b0;
    end else if (mem_cs_o) begin
      if (mem_we_o) begin
        mem[mem_addr_o[9:0]]  <= mem_wdata_o;
        memi[mem_addr_o[9:0]] <= mem_wdata_intg_o;
      end else begin
        mem_rdata_i      <= mem[mem_addr_o[9:0]];
        mem_rdata_intg_i <= memi[mem_addr_o[9:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    core_cs_i = 1'b0; core_addr_i = 16'h0;
    ext_req_i = 1'b0; ext_we_i = 1'b0; ext_addr_i = 16'h0;
    ext_wdata_i = 32'h0; ext_wdata_intg_i = 7'h0;
    cyc(); cyc();
    chk("rst_rvalid", 32'(ext_rvalid_o), 32'd0);
    chk("rst_err",    32'(ext_err_o),    32'd0);
    chk("rst_starve", 32'(ext_starve_o), 32'd0);
    chk("rst_stall",  32'(ext_stall_cnt_o), 32'd0);
    rst_i = 1'b0;
    cyc();

    // Core priority over a simultaneous ext read.
    core_cs_i = 1'b1; core_addr_i = 16'h0010;
    ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 16'h0020;
    #1;
    chk("prio_addr", 32'(mem_addr_o), 32'h10);
    chk("prio_gnt",  32'(ext_gnt_o),  32'd0);
    chk("prio_we",   32'(mem_we_o),   32'd0);
    cyc();
    chk("core_rdata", core_rdata_o, 32'hCAFE0010);
    chk("core_intg",  32'(core_rdata_intg_o), 32'h10);
    core_cs_i = 1'b0;
    #1;
    chk("ext_gnt",    32'(ext_gnt_o),  32'd1);
    chk("ext_addr",   32'(mem_addr_o), 32'h20);
    chk("ext_norv",   32'(ext_rvalid_o), 32'd0);
    cyc();
    chk("ext_rvalid", 32'(ext_rvalid_o), 32'd1);
    chk("ext_rdata",  ext_rdata_o, 32'h12345678);
    chk("ext_rintg",  32'(ext_rdata_intg_o), 32'h2A);
    chk("ext_noerr",  32'(ext_err_o), 32'd0);
    chk("stall_one",  32'(ext_stall_cnt_o), 32'd1);

    // Back-to-back ext write then read of the same index.
    ext_we_i = 1'b1; ext_addr_i = 16'h0005;
    ext_wdata_i = 32'hDEADBEEF; ext_wdata_intg_i = 7'h11;
    #1;
    chk("wr_gnt",   32'(ext_gnt_o), 32'd1);
    chk("wr_we",    32'(mem_we_o),  32'd1);
    chk("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
    cyc();
    chk("wr_rvalid", 32'(ext_rvalid_o), 32'd1);
    chk("wr_rdata0", ext_rdata_o, 32'h0);
    ext_we_i = 1'b0;
    #1;
    chk("rd_gnt", 32'(ext_gnt_o), 32'd1);
    cyc();
    chk("rd_rvalid", 32'(ext_rvalid_o), 32'd1);
    chk("rd_rdata",  ext_rdata_o, 32'hDEADBEEF);
    chk("rd_rintg",  32'(ext_rdata_intg_o), 32'h11);
    ext_req_i = 1'b0;
    cyc();
    chk("idle_rvalid", 32'(ext_rvalid_o), 32'd0);

    // Last legal index, then the first out-of-range index.
    ext_req_i = 1'b1; ext_addr_i = 16'h03FF;
    #1;
    chk("edge_cs", 32'(mem_cs_o), 32'd1);
    cyc();
    chk("edge_err",   32'(ext_err_o), 32'd0);
    chk("edge_rdata", ext_rdata_o, 32'h000003FF);
    ext_addr_i = 16'h0400;
    #1;
    chk("oor_gnt", 32'(ext_gnt_o), 32'd1);
    chk("oor_cs",  32'(mem_cs_o),  32'd0);
    cyc();
    chk("oor_rvalid", 32'(ext_rvalid_o), 32'd1);
    chk("oor_err",    32'(ext_err_o), 32'd1);
    chk("oor_rdata",  ext_rdata_o, 32'h0);
    chk("oor_rintg",  32'(ext_rdata_intg_o), 32'h0);

    // Async reset while a response is being presented.
    ext_addr_i = 16'h0020;
    cyc();
    chk("prerst_rvalid", 32'(ext_rvalid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("arst_rvalid", 32'(ext_rvalid_o), 32'd0);
    chk("arst_stall",  32'(ext_stall_cnt_o), 32'd0);
    chk("arst_starve", 32'(ext_starve_o), 32'd0);
    ext_req_i = 1'b0;
    cyc();
    rst_i = 1'b0;
    cyc();
    chk("postrst_rvalid", 32'(ext_rvalid_o), 32'd0);

    // Starvation: 20 stalled cycles under continuous core traffic.
    core_cs_i = 1'b1; core_addr_i = 16'h0010;
    ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 16'h0020;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 14) chk("starve_14", 32'(ext_starve_o), 32'd0);
      if (i == 15) chk("starve_15", 32'(ext_starve_o), 32'd1);
    end
    chk("starve_20",   32'(ext_starve_o), 32'd1);
    chk("stall_20",    32'(ext_stall_cnt_o), 32'd20);
    chk("stall_sat4",  32'(d2_stall_cnt), 32'd15);
    core_cs_i = 1'b0;
    #1;
    chk("rel_gnt", 32'(ext_gnt_o), 32'd1);
    cyc();
    chk("rel_starve", 32'(ext_starve_o), 32'd0);
    chk("rel_rdata",  ext_rdata_o, 32'h12345678);
    chk("rel_stall",  32'(ext_stall_cnt_o), 32'd20);

    // Same-index conflict: core wins, ext write waits a cycle.
    core_cs_i = 1'b1; core_addr_i = 16'h0007;
    ext_we_i = 1'b1; ext_addr_i = 16'h0007;
    ext_wdata_i = 32'hA5A5A5A5; ext_wdata_intg_i = 7'h55;
    #1;
    chk("conf_gnt", 32'(ext_gnt_o), 32'd0);
    chk("conf_we",  32'(mem_we_o),  32'd0);
    cyc();
    core_cs_i = 1'b0;
    #1;
    chk("conf_wgnt", 32'(ext_gnt_o), 32'd1);
    cyc();
    ext_req_i = 1'b0; ext_we_i = 1'b0;
    core_cs_i = 1'b1;
    cyc();
    chk("raw_core", core_rdata_o, 32'hA5A5A5A5);
    chk("raw_stall",  32'(ext_stall_cnt_o), 32'd21);
    chk("raw_sat4",   32'(d2_stall_cnt), 32'd15);
    core_cs_i = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
